mips_mc_ctrl: RTL
=================

Name: mips_mc_ctrl

Overview:
Multicycle MIPS control unit. A Moore FSM sequences the shared datapath (PC, PCAdd, memory, IR, register file, SignExtend/Shift_Left, Mux2_1 selects, ALU via ALUControl) through fetch, decode, execute, memory and writeback. Memory accesses stall on a ready handshake, and a watchdog aborts stuck accesses. The block sits beside the datapath and drives every select and write-enable.

Parameters:
MEM_TIMEOUT, 15, number of consecutive mem_ready=0 cycles in one memory state before the access is aborted (range 1..255).
WAIT_W, 8, width of the wait counter; must satisfy 2^WAIT_W > MEM_TIMEOUT.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  6  IR[31:26]
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the access this cycle
pc_en  out  1  PC register load enable = pc_write | (branch & zero)
iord  out  1  memory address mux: 0=PC, 1=ALUOut
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
ir_write  out  1  IR load enable
reg_dst  out  1  write register: 0=rt, 1=rd
mem_to_reg  out  1  writeback data: 0=ALUOut, 1=MDR
reg_write  out  1  register file write enable
alu_srca  out  1  ALU A: 0=PC, 1=rs
alu_srcb  out  2  ALU B: 00=rt, 01=const 4, 10=SignImm, 11=SignImm<<2
alu_op  out  2  to ALUControl: 00=add, 01=sub, 10=funct
pc_src  out  2  00=ALU result, 01=ALUOut, 10=jump target
mem_err  out  1  sticky; set on watchdog abort
state  out  4  current state encoding (debug)

Behaviour:
- Clock and reset: single clock domain, clk; asynchronous active-low reset rst_n. While rst_n=0: state=FETCH(0), wait counter=0, mem_err=0, and all outputs are forced to 0 combinationally, including mem_read.
- States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11, TRAP 12 (TRAP exists only with the option).
- Outputs are Moore outputs from the state. The only exceptions are mem_ready qualification and the zero term in pc_en.
- FETCH: iord=0, mem_read=1, alu_srca=0, alu_srcb=01, alu_op=00, pc_src=00. ir_write=mem_ready and pc_write=mem_ready. If mem_ready, go to DECODE; otherwise stay.
- DECODE: alu_srca=0, alu_srcb=11, alu_op=00 (branch target precompute). Next state by opcode:
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 000000 (R-type) -> EXECUTE
  - 000100 (beq) -> BRANCH
  - 001000 (addi) -> ADDIEX
  - 000010 (j) -> JUMP
  - any other opcode -> illegal (see Optional Feature)
- MEMADR: alu_srca=1, alu_srcb=10, alu_op=00. lw goes to MEMRD, sw goes to MEMWR.
- MEMRD: iord=1, mem_read=1. Stays until mem_ready, then goes to MEMWB.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1. Next state FETCH.
- MEMWR: iord=1, mem_write=1. Stays until mem_ready, then goes to FETCH.
- EXECUTE: alu_srca=1, alu_srcb=00, alu_op=10. Next state ALUWB.
- ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1. Next state FETCH.
- BRANCH: alu_srca=1, alu_srcb=00, alu_op=01, pc_src=01, branch=1, so pc_en=zero. Next state FETCH.
- ADDIEX: alu_srca=1, alu_srcb=10, alu_op=00. Next state ADDIIWB.
- ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1. Next state FETCH.
- JUMP: pc_src=10, pc_write=1. Next state FETCH.
- Instruction latency with zero-wait memory: lw 5 cycles; sw, R-type, addi 4 cycles; beq, j 3 cycles. Each memory wait cycle adds 1.
- Wait counter:
  - Increments each cycle spent in FETCH, MEMRD or MEMWR with mem_ready=0.
  - Clears on mem_ready=1 or on any state change.
  - When it reaches MEM_TIMEOUT while mem_ready=0: mem_err is set (sticky until reset), no enable is pulsed, and the next state is FETCH.
  - In that abort cycle, a mem_ready arriving on the same cycle wins: the access completes normally.
  - A FETCH abort re-fetches the same PC, since PC was not written.
- Write enables (pc_en, ir_write, reg_write, mem_write) never assert outside the states listed above.
- Reset asserted mid-instruction returns to FETCH immediately, with no partial writeback.

Optional Feature:
MIPS_ILLEGAL_TRAP_EN.
- Defined: an illegal opcode in DECODE goes to TRAP. TRAP drives all outputs 0 and stays until reset; state=12.
- Undefined: an illegal opcode in DECODE goes to FETCH (treated as NOP; PC already advanced). TRAP is not synthesized.

Test Plan:
- Reset low at cycle 3 of lw -> state=0, all outputs 0 while rst_n=0; first cycle after release: mem_read=1, alu_srcb=01.
- R-type (opcode 000000), mem_ready always 1 -> states 0,1,6,7,0; alu_op=10 in state 6; reg_write=1, reg_dst=1 only in state 7.
- lw (100011) with mem_ready low 3 cycles in MEMRD -> 8 cycles total; mem_to_reg=1, reg_write=1 exactly once.
- beq (000100): zero=1 -> pc_en=1, pc_src=01 in state 8; zero=0 -> pc_en=0; both return to FETCH.
- mem_ready held 0 in FETCH with MEM_TIMEOUT=15 -> after 15 wait cycles mem_err=1, state=0, ir_write never 1; mem_err stays 1 after a later mem_ready.
- Opcode 111111: with MIPS_ILLEGAL_TRAP_EN -> state=12, held for 20 cycles with all enables 0; without it -> state returns to 0 after DECODE.

Source files
------------

// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl: multicycle MIPS control unit (Moore FSM).
// Sequences fetch/decode/execute/memory/writeback for lw, sw, R-type, beq,
// addi and j. Memory states wait on mem_ready; a watchdog aborts an access
// after MEM_TIMEOUT consecutive not-ready cycles and sets a sticky mem_err.
// Optional macro MIPS_ILLEGAL_TRAP_EN: illegal opcodes lock the FSM in TRAP
// (state 12) until reset; without it, illegal opcodes behave as a NOP.
module mips_mc_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int WAIT_W      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_srca,
  output logic [1:0] alu_srcb,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       mem_err,
  output logic [3:0] state
);

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_EXECUTE = 4'd6;
  localparam logic [3:0] S_ALUWB   = 4'd7;
  localparam logic [3:0] S_BRANCH  = 4'd8;
  localparam logic [3:0] S_ADDIEX  = 4'd9;
  localparam logic [3:0] S_ADDIWB  = 4'd10;
  localparam logic [3:0] S_JUMP    = 4'd11;
`ifdef MIPS_ILLEGAL_TRAP_EN
  localparam logic [3:0] S_TRAP    = 4'd12;
`endif

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  logic [3:0]        r_state;
  logic [3:0]        w_next_state;
  logic [WAIT_W-1:0] r_wait;
  logic [WAIT_W-1:0] w_wait_next;
  logic              r_mem_err;
  logic              w_mem_state;
  logic              w_timeout;

  // Raw (ungated) Moore outputs
  logic       w_pc_write, w_branch, w_iord, w_mem_read, w_mem_write, w_ir_write;
  logic       w_reg_dst, w_mem_to_reg, w_reg_write, w_alu_srca;
  logic [1:0] w_alu_srcb, w_alu_op, w_pc_src;

  // Abort fires on the MEM_TIMEOUT-th consecutive not-ready cycle; a
  // mem_ready in that same cycle completes the access instead.
  assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
  assign w_timeout   = w_mem_state && !mem_ready && (r_wait == WAIT_W'(MEM_TIMEOUT - 1));

  // Next-state selection
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FETCH:   if (mem_ready) w_next_state = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: w_next_state = S_MEMADR;
          OP_RTYP:      w_next_state = S_EXECUTE;
          OP_BEQ:       w_next_state = S_BRANCH;
          OP_ADDI:      w_next_state = S_ADDIEX;
          OP_J:         w_next_state = S_JUMP;
`ifdef MIPS_ILLEGAL_TRAP_EN
          default:      w_next_state = S_TRAP;
`else
          default:      w_next_state = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:  w_next_state = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        if (mem_ready)      w_next_state = S_MEMWB;
        else if (w_timeout) w_next_state = S_FETCH;
      end
      S_MEMWR: begin
        if (mem_ready || w_timeout) w_next_state = S_FETCH;
      end
      S_EXECUTE: w_next_state = S_ALUWB;
      S_ADDIEX:  w_next_state = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: w_next_state = S_FETCH;
`ifdef MIPS_ILLEGAL_TRAP_EN
      S_TRAP:    w_next_state = S_TRAP;
`endif
      default:   w_next_state = S_FETCH;
    endcase
  end

  // Wait counter counts consecutive not-ready cycles within one memory state
  always_comb begin
    w_wait_next = '0;
    if (w_mem_state && !mem_ready && !w_timeout && (w_next_state == r_state))
      w_wait_next = r_wait + WAIT_W'(1);
  end

  // State, wait counter and sticky error registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_wait    <= '0;
      r_mem_err <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_wait  <= w_wait_next;
      if (w_timeout) r_mem_err <= 1'b1;
    end
  end

  // Moore output decode (mem_ready qualifies the fetch enables)
  always_comb begin
    w_pc_write = 1'b0; w_branch = 1'b0; w_iord = 1'b0; w_mem_read = 1'b0;
    w_mem_write = 1'b0; w_ir_write = 1'b0; w_reg_dst = 1'b0; w_mem_to_reg = 1'b0;
    w_reg_write = 1'b0; w_alu_srca = 1'b0; w_alu_srcb = 2'b00; w_alu_op = 2'b00;
    w_pc_src = 2'b00;
    case (r_state)
      S_FETCH: begin
        w_mem_read = 1'b1; w_alu_srcb = 2'b01;
        w_ir_write = mem_ready; w_pc_write = mem_ready;
      end
      S_DECODE:  w_alu_srcb = 2'b11;
      S_MEMADR:  begin w_alu_srca = 1'b1; w_alu_srcb = 2'b10; end
      S_MEMRD:   begin w_iord = 1'b1; w_mem_read = 1'b1; end
      S_MEMWB:   begin w_mem_to_reg = 1'b1; w_reg_write = 1'b1; end
      S_MEMWR:   begin w_iord = 1'b1; w_mem_write = 1'b1; end
      S_EXECUTE: begin w_alu_srca = 1'b1; w_alu_op = 2'b10; end
      S_ALUWB:   begin w_reg_dst = 1'b1; w_reg_write = 1'b1; end
      S_BRANCH: begin
        w_alu_srca = 1'b1; w_alu_op = 2'b01; w_pc_src = 2'b01; w_branch = 1'b1;
      end
      S_ADDIEX:  begin w_alu_srca = 1'b1; w_alu_srcb = 2'b10; end
      S_ADDIWB:  w_reg_write = 1'b1;
      S_JUMP:    begin w_pc_src = 2'b10; w_pc_write = 1'b1; end
      default: ;
    endcase
  end

  // Everything is forced low while reset is held, independent of the clock
  assign pc_en      = rst_n & (w_pc_write | (w_branch & zero));
  assign iord       = rst_n & w_iord;
  assign mem_read   = rst_n & w_mem_read;
  assign mem_write  = rst_n & w_mem_write;
  assign ir_write   = rst_n & w_ir_write;
  assign reg_dst    = rst_n & w_reg_dst;
  assign mem_to_reg = rst_n & w_mem_to_reg;
  assign reg_write  = rst_n & w_reg_write;
  assign alu_srca   = rst_n & w_alu_srca;
  assign alu_srcb   = {2{rst_n}} & w_alu_srcb;
  assign alu_op     = {2{rst_n}} & w_alu_op;
  assign pc_src     = {2{rst_n}} & w_pc_src;
  assign mem_err    = rst_n & r_mem_err;
  assign state      = {4{rst_n}} & r_state;

endmodule
